// File: rtl/rvvi_tx_sched.sv
// Transmit scheduler: merges first-time and replayed RVVI packets into one MAC stream,
// giving replay strict priority, and forces a replay when acks stop arriving.
module rvvi_tx_sched #(
    parameter int WIDTH = 792,
    parameter int TOW   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             NewValid,
    output logic             NewReady,
    input  logic [WIDTH-1:0] NewData,
    input  logic             ReplayValid,
    output logic             ReplayReady,
    input  logic [WIDTH-1:0] ReplayData,
    input  logic             AckValid,
    input  logic             ALFull,
    input  logic             ALEmpty,
    input  logic [TOW-1:0]   TimeoutCycles,
    output logic             ReplayReq,
    output logic             TxValid,
    input  logic             TxReady,
    output logic [WIDTH-1:0] TxData,
    output logic             TxIsReplay,
    output logic [15:0]      ReplayCnt,
    output logic [15:0]      TimeoutCnt
);

    typedef enum logic [1:0] {IDLE, NEW, REPLAY} state_t;

    state_t           state_reg, state_next;
    logic             tx_valid_reg;
    logic [WIDTH-1:0] tx_data_reg;
    logic             tx_is_replay_reg;
    logic             reg_free;
    logic             new_ready, replay_ready;
    logic             new_acc, rep_acc;
    logic [TOW-1:0]   to_cnt_reg;
    logic             to_clear, to_fire;
    logic [1:0]       stat_inc;
    logic [1:0][15:0] stat_cnt;

    assign reg_free = ~tx_valid_reg | TxReady;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Readys are gated by reset so nothing can be offered while the block is held clear.
    always_comb begin
        state_next   = state_reg;
        new_ready    = 1'b0;
        replay_ready = 1'b0;
        if (reset && reg_free) begin
            if (state_reg == REPLAY || ReplayValid) replay_ready = 1'b1;
            else                                    new_ready    = NewValid & ~ALFull;
        end
        new_acc = NewValid & new_ready;
        rep_acc = ReplayValid & replay_ready;
        case (state_reg)
            IDLE: begin
                if (rep_acc)      state_next = REPLAY;
                else if (new_acc) state_next = NEW;
            end
            NEW: begin
                if (rep_acc)                  state_next = REPLAY;
                else if (!new_acc && reg_free) state_next = IDLE;
            end
            REPLAY: begin
                if (reg_free && !ReplayValid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_valid_reg     <= 1'b0;
            tx_data_reg      <= '0;
            tx_is_replay_reg <= 1'b0;
        end else if (reg_free) begin
            tx_valid_reg <= new_acc | rep_acc;
            if (new_acc | rep_acc) begin
                tx_data_reg      <= rep_acc ? ReplayData : NewData;
                tx_is_replay_reg <= rep_acc;
            end
        end
    end

    // An ack arriving on the terminal count clears the counter before it can fire.
    assign to_clear = AckValid | ALEmpty | (state_reg == REPLAY) | (TimeoutCycles == '0);
    assign to_fire  = ~to_clear & (to_cnt_reg == TimeoutCycles - TOW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                to_cnt_reg <= '0;
        else if (to_clear | to_fire) to_cnt_reg <= '0;
        else                       to_cnt_reg <= to_cnt_reg + TOW'(1);
    end

    assign stat_inc = {to_fire, rep_acc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)                                cnt_reg <= '0;
                else if (stat_inc[gi] && cnt_reg != 16'hFFFF) cnt_reg <= cnt_reg + 16'd1;
            end
            assign stat_cnt[gi] = cnt_reg;
        end
    endgenerate

    assign NewReady    = new_ready;
    assign ReplayReady = replay_ready;
    assign ReplayReq   = to_fire & reset;
    assign TxValid     = tx_valid_reg;
    assign TxData      = tx_data_reg;
    assign TxIsReplay  = tx_is_replay_reg;
    assign ReplayCnt   = stat_cnt[0];
    assign TimeoutCnt  = stat_cnt[1];

endmodule

// File: tb/tb_rvvi_tx_sched.sv
// Directed bench for rvvi_tx_sched: new/replay priority, backpressure, ALFull gating,
// reset mid-burst and the ack timeout.
module tb_rvvi_tx_sched;
    localparam int W   = 32;
    localparam int TOW = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           NewValid, NewReady;
    logic [W-1:0]   NewData;
    logic           ReplayValid, ReplayReady;
    logic [W-1:0]   ReplayData;
    logic           AckValid, ALFull, ALEmpty;
    logic [TOW-1:0] TimeoutCycles;
    logic           ReplayReq;
    logic           TxValid, TxReady, TxIsReplay;
    logic [W-1:0]   TxData;
    logic [15:0]    ReplayCnt, TimeoutCnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rvvi_tx_sched #(.WIDTH(W), .TOW(TOW)) dut (
        .clk(clk), .reset(reset),
        .NewValid(NewValid), .NewReady(NewReady), .NewData(NewData),
        .ReplayValid(ReplayValid), .ReplayReady(ReplayReady), .ReplayData(ReplayData),
        .AckValid(AckValid), .ALFull(ALFull), .ALEmpty(ALEmpty),
        .TimeoutCycles(TimeoutCycles), .ReplayReq(ReplayReq),
        .TxValid(TxValid), .TxReady(TxReady), .TxData(TxData), .TxIsReplay(TxIsReplay),
        .ReplayCnt(ReplayCnt), .TimeoutCnt(TimeoutCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; NewValid = 1'b1; NewData = 32'hDEAD; ReplayValid = 1'b0; ReplayData = '0;
        AckValid = 1'b0; ALFull = 1'b0; ALEmpty = 1'b1; TimeoutCycles = '0; TxReady = 1'b1;
        #12;
        check("rst_txvalid", TxValid, 0);
        check("rst_txdata", TxData, 0);
        check("rst_isreplay", TxIsReplay, 0);
        check("rst_newready", NewReady, 0);
        check("rst_replayready", ReplayReady, 0);
        check("rst_replayreq", ReplayReq, 0);
        check("rst_replaycnt", ReplayCnt, 0);
        check("rst_timeoutcnt", TimeoutCnt, 0);

        // First accept on the first edge after release
        reset = 1'b1; NewData = 32'hA5; #1;
        check("first_newready", NewReady, 1);
        step();
        check("first_txvalid", TxValid, 1);
        check("first_txdata", TxData, 32'hA5);
        check("first_isreplay", TxIsReplay, 0);
        for (int i = 1; i <= 3; i++) begin
            NewData = 32'(i); step();
            check("stream_data", TxData, 64'(i));
            check("stream_valid", TxValid, 1);
        end
        NewValid = 1'b0; step();
        check("stream_end", TxValid, 0);

        // Replay beats win over a simultaneous new packet
        NewValid = 1'b1; NewData = 32'h11; ReplayValid = 1'b1; ReplayData = 32'h100; #1;
        check("prio_replayready", ReplayReady, 1);
        check("prio_newready", NewReady, 0);
        step();
        check("prio_data0", TxData, 32'h100);
        check("prio_isrep0", TxIsReplay, 1);
        ReplayData = 32'h101; #1;
        check("burst_newready", NewReady, 0);
        step();
        check("prio_data1", TxData, 32'h101);
        ReplayValid = 1'b0; #1;
        check("burst_end_newrdy", NewReady, 0);
        step();
        check("burst_end_valid", TxValid, 0);
        check("after_newready", NewReady, 1);
        step();
        check("after_data", TxData, 32'h11);
        check("after_isreplay", TxIsReplay, 0);
        check("replaycnt_2", ReplayCnt, 2);

        // Backpressure: hold beat for 5 cycles
        NewData = 32'h22; TxReady = 1'b0; ReplayValid = 1'b0; #1;
        check("bp_newready0", NewReady, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", TxValid, 1);
            check("bp_data", TxData, 32'h11);
            check("bp_newready", NewReady, 0);
            check("bp_replayready", ReplayReady, 0);
        end
        TxReady = 1'b1; #1;
        check("bp_release_rdy", NewReady, 1);
        step();
        check("bp_next_data", TxData, 32'h22);
        NewValid = 1'b0; step();
        check("bp_drained", TxValid, 0);

        // ALFull blocks new packets only
        ALFull = 1'b1; NewValid = 1'b1; NewData = 32'h33; #1;
        check("full_newready", NewReady, 0);
        step();
        check("full_no_tx", TxValid, 0);
        ReplayValid = 1'b1; ReplayData = 32'h200; #1;
        check("full_replayready", ReplayReady, 1);
        step();
        check("full_rep_data", TxData, 32'h200);
        check("full_rep_isrep", TxIsReplay, 1);
        check("replaycnt_3", ReplayCnt, 3);

        // Reset mid-replay
        #2 reset = 1'b0; #1;
        check("midrst_txvalid", TxValid, 0);
        check("midrst_txdata", TxData, 0);
        check("midrst_replaycnt", ReplayCnt, 0);
        check("midrst_timeoutcnt", TimeoutCnt, 0);
        check("midrst_replayrdy", ReplayReady, 0);
        NewValid = 1'b0; ReplayValid = 1'b0; ALFull = 1'b0;
        #3 reset = 1'b1;
        step();
        check("postrst_txvalid", TxValid, 0);

        // Timeout: pulse every 8 cycles without acks
        ALEmpty = 1'b0; TimeoutCycles = 16'd8;
        for (int k = 0; k < 16; k++) begin
            #1;
            check("to_replayreq", ReplayReq, 64'(k == 7 || k == 15));
            step();
        end
        check("to_cnt_2", TimeoutCnt, 2);
        // Ack on terminal count suppresses the pulse
        for (int k = 0; k < 8; k++) begin
            AckValid = (k == 7); #1;
            check("ack_replayreq", ReplayReq, 0);
            step();
        end
        AckValid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("to2_replayreq", ReplayReq, 64'(k == 7));
            step();
        end
        check("to_cnt_3", TimeoutCnt, 3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
